// File: rtl/decode_operand_fetch_ctrl_pkg.sv
// Shared types and constants for the displacement/immediate fetch sequencer.
package decode_operand_fetch_ctrl_pkg;

    typedef enum logic [3:0] {
        LEN_8    = 4'b0001,
        LEN_16   = 4'b0010,
        LEN_32   = 4'b0100,
        LEN_FULL = 4'b1000
    } len_onehot_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DISP = 2'd1,
        IMM  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Byte counter must reach the largest field (ptr16:32 immediate = 6 bytes).
    localparam int CNT_W                = 3;
    localparam int FULL_IMM_BYTES_DFLT  = 6;
    localparam int FULL_DISP_BYTES_DFLT = 4;

endpackage

// File: rtl/decode_operand_fetch_ctrl_if.sv
// Descriptor, prefetch-queue and result bundle between decode, prefetch queue and issue.
interface decode_operand_fetch_ctrl_if;
    logic        flush;
    logic        start;
    logic        displacement_is_present;
    logic [3:0]  displacement_length;
    logic        immediate_is_present;
    logic [3:0]  immediate_length;
    logic        q_valid;
    logic [7:0]  q_byte;
    logic        q_ready;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] displacement;
    logic [31:0] immediate;
    logic [15:0] selector;

    modport master (
        output flush, start, displacement_is_present, displacement_length,
               immediate_is_present, immediate_length, q_valid, q_byte,
        input  q_ready, busy, done, error, displacement, immediate, selector
    );

    modport slave (
        input  flush, start, displacement_is_present, displacement_length,
               immediate_is_present, immediate_length, q_valid, q_byte,
        output q_ready, busy, done, error, displacement, immediate, selector
    );
endinterface

// File: rtl/decode_operand_fetch_ctrl_operand_length_to_count.sv
// Maps a one-hot field length plus present bit to a byte count and an illegal flag.
module operand_length_to_count
    import decode_operand_fetch_ctrl_pkg::*;
#(
    parameter int FULL_BYTES = 4
) (
    input  logic             i_present,
    input  logic [3:0]       i_len,
    output logic [CNT_W-1:0] o_count,
    output logic             o_illegal
);
    always_comb begin
        o_count   = '0;
        o_illegal = 1'b0;
        if (i_present) begin
            case (i_len)
                LEN_8:    o_count = CNT_W'(1);
                LEN_16:   o_count = CNT_W'(2);
                LEN_32:   o_count = CNT_W'(4);
                LEN_FULL: o_count = CNT_W'(FULL_BYTES);
                default:  o_illegal = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/decode_operand_fetch_ctrl.sv
// Pulls displacement then immediate bytes from the prefetch queue and assembles them little-endian.
module decode_operand_fetch_ctrl
    import decode_operand_fetch_ctrl_pkg::*;
#(
    parameter int FULL_IMM_BYTES  = FULL_IMM_BYTES_DFLT,
    parameter int FULL_DISP_BYTES = FULL_DISP_BYTES_DFLT
) (
    input  logic clock,
    input  logic reset_n,
    decode_operand_fetch_ctrl_if.slave bus
);
    state_e           r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_disp_cnt;
    logic [CNT_W-1:0] r_imm_cnt;
    logic             r_done;
    logic             r_error;
    logic [31:0]      r_displacement;
    logic [31:0]      r_immediate;
    logic [15:0]      r_selector;

    logic [CNT_W-1:0] w_disp_cnt;
    logic [CNT_W-1:0] w_imm_cnt;
    logic             w_disp_illegal;
    logic             w_imm_illegal;
    logic             w_q_ready;
    logic             w_accept;
    logic             w_disp_last;
    logic             w_imm_last;

    operand_length_to_count #(.FULL_BYTES(FULL_DISP_BYTES)) u_disp_len (
        .i_present (bus.displacement_is_present),
        .i_len     (bus.displacement_length),
        .o_count   (w_disp_cnt),
        .o_illegal (w_disp_illegal)
    );

    operand_length_to_count #(.FULL_BYTES(FULL_IMM_BYTES)) u_imm_len (
        .i_present (bus.immediate_is_present),
        .i_len     (bus.immediate_length),
        .o_count   (w_imm_cnt),
        .o_illegal (w_imm_illegal)
    );

    // Flush must block the byte accept in the same cycle it is raised.
    assign w_q_ready   = ((r_state == DISP) || (r_state == IMM)) && !bus.flush;
    assign w_accept    = w_q_ready && bus.q_valid;
    assign w_disp_last = (r_count == (r_disp_cnt - CNT_W'(1)));
    assign w_imm_last  = (r_count == (r_imm_cnt - CNT_W'(1)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_count        <= '0;
            r_disp_cnt     <= '0;
            r_imm_cnt      <= '0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_displacement <= '0;
            r_immediate    <= '0;
            r_selector     <= '0;
        end else if (bus.flush) begin
            r_state <= IDLE;
            r_count <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_displacement <= '0;
                        r_immediate    <= '0;
                        r_selector     <= '0;
                        r_count        <= '0;
                        r_disp_cnt     <= w_disp_cnt;
                        r_imm_cnt      <= w_imm_cnt;
                        if (w_disp_illegal || w_imm_illegal) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_error <= 1'b1;
                        end else if (w_disp_cnt != '0) begin
                            r_state <= DISP;
                        end else if (w_imm_cnt != '0) begin
                            r_state <= IMM;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DISP: begin
                    if (w_accept) begin
                        case (r_count)
                            3'd0:    r_displacement[7:0]   <= bus.q_byte;
                            3'd1:    r_displacement[15:8]  <= bus.q_byte;
                            3'd2:    r_displacement[23:16] <= bus.q_byte;
                            3'd3:    r_displacement[31:24] <= bus.q_byte;
                            default: ;
                        endcase
                        if (w_disp_last) begin
                            r_count <= '0;
                            if (r_imm_cnt != '0) begin
                                r_state <= IMM;
                            end else begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                IMM: begin
                    // Lanes 4-5 of a far pointer carry the segment selector.
                    if (w_accept) begin
                        case (r_count)
                            3'd0:    r_immediate[7:0]   <= bus.q_byte;
                            3'd1:    r_immediate[15:8]  <= bus.q_byte;
                            3'd2:    r_immediate[23:16] <= bus.q_byte;
                            3'd3:    r_immediate[31:24] <= bus.q_byte;
                            3'd4:    r_selector[7:0]    <= bus.q_byte;
                            3'd5:    r_selector[15:8]   <= bus.q_byte;
                            default: ;
                        endcase
                        if (w_imm_last) begin
                            r_count <= '0;
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.q_ready      = w_q_ready;
    assign bus.busy         = (r_state != IDLE);
    assign bus.done         = r_done;
    assign bus.error        = r_error;
    assign bus.displacement = r_displacement;
    assign bus.immediate    = r_immediate;
    assign bus.selector     = r_selector;

endmodule

// File: tb/tb_decode_operand_fetch_ctrl.sv
// Scoreboard bench: driver queues expected results from a byte-stream model, monitor checks each done.
module tb_decode_operand_fetch_ctrl;

    localparam int FULL_IMM  = 6;
    localparam int FULL_DISP = 4;

    typedef struct {
        logic [31:0] d;
        logic [31:0] i;
        logic [15:0] s;
        logic        e;
        int          n;
        int          lat;
        int          start_cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   done_cnt;
    int   consumed;
    int   rdy_cycles;
    int   rdy_low;
    int   stall_pct;
    exp_t exp_q[$];
    logic [7:0] feed_q[$];
    bit   vpat[$];

    decode_operand_fetch_ctrl_if bus ();

    decode_operand_fetch_ctrl dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int len_bytes(input logic [3:0] l, input int full);
        case (l)
            4'b0001: return 1;
            4'b0010: return 2;
            4'b0100: return 4;
            4'b1000: return full;
            default: return -1;
        endcase
    endfunction

    function automatic logic [3:0] rand_len();
        if ($urandom_range(9) == 0) return 4'($urandom_range(15));
        return 4'(1 << $urandom_range(3));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pops one expectation.
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("displacement", bus.displacement, e.d);
                    check("immediate", bus.immediate, e.i);
                    check("selector", 32'(bus.selector), 32'(e.s));
                    check("error", 32'(bus.error), 32'(e.e));
                    check("bytes_consumed", 32'(consumed), 32'(e.n));
                    if (e.lat >= 0) check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
                end
            end
        end
    endtask

    // Prefetch queue model: presents feed_q head, samples accept just before the edge.
    task automatic feeder_loop();
        bit v;
        forever begin
            @(negedge clk);
            #2;
            if (vpat.size() > 0) v = vpat.pop_front();
            else v = ($urandom_range(99) >= stall_pct);
            if (v && feed_q.size() > 0) begin
                bus.q_valid = 1'b1;
                bus.q_byte  = feed_q[0];
            end else begin
                bus.q_valid = 1'b0;
                bus.q_byte  = 8'($urandom);
            end
            #2;
            if (bus.q_ready) rdy_cycles++;
            else if (bus.busy && !bus.done) rdy_low++;
            if (bus.q_valid && bus.q_ready) begin
                consumed++;
                void'(feed_q.pop_front());
            end
        end
    endtask

    task automatic run_txn(input logic dp, input logic [3:0] dl, input logic ip, input logic [3:0] il,
                           input logic [7:0] bytes[$], input int spct, input bit extra_start,
                           input bit pat[$], input int lat_override);
        exp_t e;
        int   nd, ni, d0;
        nd = len_bytes(dl, FULL_DISP);
        ni = len_bytes(il, FULL_IMM);
        e.d = '0; e.i = '0; e.s = '0; e.e = 1'b0; e.n = 0;
        if ((dp && nd < 0) || (ip && ni < 0)) begin
            e.e   = 1'b1;
            e.lat = 1;
        end else begin
            if (!dp) nd = 0;
            if (!ip) ni = 0;
            for (int k = 0; k < nd; k++) e.d = e.d + (32'(bytes[k]) << (8 * k));
            for (int k = 0; k < ni; k++) begin
                if (k < 4) e.i = e.i + (32'(bytes[nd + k]) << (8 * k));
                else       e.s = e.s + (16'(bytes[nd + k]) << (8 * (k - 4)));
            end
            e.n   = nd + ni;
            e.lat = (spct == 0) ? e.n + 1 : -1;
        end
        if (lat_override >= 0) e.lat = lat_override;

        @(negedge clk); #1;
        bus.displacement_is_present = dp;
        bus.displacement_length     = dl;
        bus.immediate_is_present    = ip;
        bus.immediate_length        = il;
        bus.start   = 1'b1;
        stall_pct   = spct;
        vpat        = pat;
        feed_q      = bytes;
        feed_q.push_back(8'hEE);
        feed_q.push_back(8'hDD);
        consumed    = 0;
        rdy_cycles  = 0;
        rdy_low     = 0;
        e.start_cyc = cyc;
        d0          = done_cnt;
        exp_q.push_back(e);

        @(negedge clk); #1;
        bus.start = extra_start;
        if (extra_start) begin
            bus.displacement_is_present = 1'b1;
            bus.displacement_length     = 4'b0001;
        end
        @(negedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 400 && done_cnt == d0; k++) begin
            @(negedge clk); #1;
        end
        if (done_cnt == d0) begin
            check("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
        feed_q.delete();
        vpat.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         nopat[$];
        logic [7:0] b[$];
        bit         p[$];

        cyc = 0; n_cmp = 0; n_err = 0; done_cnt = 0; consumed = 0;
        rdy_cycles = 0; rdy_low = 0; stall_pct = 0;
        rst_n = 1'b0;
        bus.flush = 1'b0; bus.start = 1'b0;
        bus.displacement_is_present = 1'b0; bus.displacement_length = 4'b0000;
        bus.immediate_is_present = 1'b0; bus.immediate_length = 4'b0000;
        bus.q_valid = 1'b0; bus.q_byte = 8'h00;

        fork
            monitor_loop();
            feeder_loop();
        join_none

        // Reset with a valid byte on offer.
        feed_q = '{8'h11, 8'h22, 8'h33};
        repeat (3) @(negedge clk);
        #3;
        check("rst_q_valid_driven", 32'(bus.q_valid), 32'd1);
        check("rst_q_ready", 32'(bus.q_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_displacement", bus.displacement, 32'd0);
        check("rst_immediate", bus.immediate, 32'd0);
        check("rst_selector", 32'(bus.selector), 32'd0);
        feed_q.delete();
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);

        // Neither field present.
        b = '{8'h5A};
        run_txn(1'b0, 4'b0000, 1'b0, 4'b0000, b, 0, 1'b0, nopat, -1);
        check("none_no_ready", 32'(rdy_cycles), 32'd0);

        // disp16 + imm8 back-to-back.
        b = '{8'h34, 8'h12, 8'h7F};
        run_txn(1'b1, 4'b0010, 1'b1, 4'b0001, b, 0, 1'b0, nopat, 4);

        // disp32 with q_valid stalls: first pattern slot covers the start cycle.
        b = '{8'h78, 8'h56, 8'h34, 8'h12};
        p = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_txn(1'b1, 4'b0100, 1'b0, 4'b0000, b, 100, 1'b0, p, 8);
        check("stall_ready_held", 32'(rdy_low), 32'd0);

        // Far pointer immediate.
        b = '{8'h00, 8'h10, 8'h00, 8'h00, 8'h08, 8'h00};
        run_txn(1'b0, 4'b0000, 1'b1, 4'b1000, b, 0, 1'b0, nopat, 7);

        // Illegal displacement length.
        b = '{8'h99, 8'h88};
        run_txn(1'b1, 4'b0011, 1'b0, 4'b0000, b, 0, 1'b0, nopat, 1);
        check("illegal_no_ready", 32'(rdy_cycles), 32'd0);

        // Illegal length on an absent field is ignored.
        b = '{8'hC3, 8'hA5};
        run_txn(1'b1, 4'b0001, 1'b0, 4'b0000, b, 0, 1'b0, nopat, -1);

        // Flush after two displacement bytes.
        @(negedge clk); #1;
        bus.displacement_is_present = 1'b1; bus.displacement_length = 4'b0100;
        bus.immediate_is_present = 1'b0;
        bus.start = 1'b1; stall_pct = 0; consumed = 0;
        feed_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        @(negedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 20 && consumed < 2; k++) begin
            @(negedge clk); #1;
        end
        check("flush_pre_bytes", 32'(consumed), 32'd2);
        bus.flush = 1'b1;
        #2;
        check("flush_q_ready", 32'(bus.q_ready), 32'd0);
        @(negedge clk); #1;
        bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_no_consume", 32'(consumed), 32'd2);
        feed_q.delete();
        repeat (2) @(negedge clk);

        // New instruction after flush, with a start pulse while busy.
        b = '{8'hAB};
        run_txn(1'b0, 4'b0000, 1'b1, 4'b0001, b, 0, 1'b1, nopat, 2);

        // Randomized descriptors, bytes and stalls.
        for (int t = 0; t < 150; t++) begin
            int sp;
            b.delete();
            for (int k = 0; k < 10; k++) b.push_back(8'($urandom));
            sp = ($urandom_range(2) == 0) ? 0 : int'($urandom_range(60));
            run_txn(1'($urandom), rand_len(), 1'($urandom), rand_len(), b, sp,
                    1'($urandom), nopat, -1);
            if ($urandom_range(3) == 0) @(negedge clk);
        end

        // Asynchronous reset in the middle of a displacement.
        @(negedge clk); #1;
        bus.displacement_is_present = 1'b1; bus.displacement_length = 4'b0100;
        bus.immediate_is_present = 1'b0;
        bus.start = 1'b1; stall_pct = 0;
        feed_q = '{8'hF1, 8'hF2, 8'hF3, 8'hF4};
        @(negedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk); #1;
        check("mid_busy_before_reset", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_q_ready", 32'(bus.q_ready), 32'd0);
        check("mid_rst_displacement", bus.displacement, 32'd0);
        check("mid_rst_immediate", bus.immediate, 32'd0);
        feed_q.delete();
        @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
